ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning byte-address width of instruction memory.
REQ-002 SHALL have parameter INST_WIDTH, default 32, meaning assembled instruction width; fixed at 4 bytes.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum wait cycles per byte before abort.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  start fetch at pc; sampled only in IDLE.
REQ-007 flush  input  1  abort any fetch in progress; return to IDLE.
REQ-008 pc  input  ADDR_WIDTH  byte address of instruction; latched when en accepted.
REQ-009 mem_addr  output  ADDR_WIDTH  byte address to memory.
REQ-010 mem_rd  output  1  read request; held with mem_addr stable until mem_ready.
REQ-011 mem_data  input  8  read byte; valid when mem_ready high.
REQ-012 mem_ready  input  1  memory acknowledge for current byte.
REQ-013 inst  output  INST_WIDTH  assembled instruction word for the decoder.
REQ-014 ready  output  1  one-cycle pulse: inst newly valid.
REQ-015 busy  output  1  high in FETCH and DONE.
REQ-016 err  output  1  one-cycle pulse: fetch aborted on timeout.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-018 IDLE -> FETCH when en=1 and flush=0; pc latched as base, byte index cleared, wait counter cleared.
REQ-019 In FETCH, mem_rd SHALL be 1 and mem_addr SHALL equal base + index, modulo 2^ADDR_WIDTH (wrap, no error).
REQ-020 On an edge with mem_ready=1 in FETCH, mem_data SHALL be written to inst[8*index+7 : 8*index] (little-endian), index incremented, wait counter cleared.
REQ-021 FETCH -> DONE on the edge capturing byte index 3.
REQ-022 DONE SHALL last exactly one cycle with ready=1, then -> IDLE.
REQ-023 Latency with mem_ready tied high: en sampled at edge N, ready high in cycle following edge N+4 (4 FETCH cycles, 1 DONE cycle).
REQ-024 inst SHALL hold its last completed value in IDLE and update only byte-by-byte during FETCH; decoder samples it when ready=1.
REQ-025 en while busy SHALL be ignored; no queueing.
REQ-026 Wait counter SHALL increment each FETCH cycle with mem_ready=0; on reaching TIMEOUT, err pulses one cycle, state -> IDLE, ready not asserted.
REQ-027 flush SHALL take priority over en, mem_ready, and timeout: next state IDLE, mem_rd=0, ready=0, err=0; partially written inst bytes retained.
REQ-028 Outside FETCH, mem_rd SHALL be 0 and mem_addr SHALL hold base.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE from any state, including mid-fetch.
REQ-030 Reset values: inst=0, mem_addr=0, mem_rd=0, ready=0, busy=0, err=0, base=0, index=0, wait counter=0.
REQ-031 rst_n SHALL take priority over flush and en.

Structure
REQ-032 FSM state encoding and the bytes-per-instruction constant (4) SHALL reside in the shared core package alongside opcode constants.
REQ-033 No sub-module; single module with one sequential process and one combinational next-state/output process.

Verification
REQ-034 mem_ready tied 1, pc=0x10, bytes 0x93,0x00,0x50,0x00 -> mem_addr 0x10..0x13, ready pulse at edge N+5, inst=0x00500093.
REQ-035 pc=0xFE, wrap -> mem_addr sequence 0xFE,0xFF,0x00,0x01; inst assembled in that order.
REQ-036 mem_ready low 3 cycles per byte -> mem_addr/mem_rd stable throughout stall; ready at edge N+17; inst correct.
REQ-037 mem_ready held 0, TIMEOUT=15 -> err pulse after 15 wait cycles, no ready, busy drops, mem_rd=0.
REQ-038 flush after byte 1 captured -> IDLE next edge, no ready; en simultaneous with flush in IDLE -> no fetch started.
REQ-039 rst_n=0 during FETCH after byte 2 -> all outputs at reset values next edge; en pulsed during FETCH -> ignored.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared core definitions: fetch FSM encoding, instruction geometry and base opcodes.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned BytesPerInst = 4;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/ifetch.sv
// Byte-serial instruction fetch: reads four little-endian bytes from a byte-wide memory
// starting at pc and presents the assembled word, with per-byte timeout and flush.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IdxW  = $clog2(BytesPerInst);
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic [INST_WIDTH-1:0]   inst_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic                    mem_rd_d, ready_d, busy_d, err_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    inst_d  = inst;
    ready_d = 1'b0;
    err_d   = 1'b0;

    // flush wins over everything; captured bytes stay in inst
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_d = StFetch;
            base_d  = pc;
            idx_d   = '0;
            wait_d  = '0;
          end
        end
        StFetch: begin
          if (mem_ready) begin
            inst_d[{idx_q, 3'b000} +: 8] = mem_data;
            idx_d  = idx_q + 1'b1;
            wait_d = '0;
            if (idx_q == IdxW'(BytesPerInst - 1)) begin
              state_d = StDone;
              ready_d = 1'b1;
            end
          end else begin
            wait_d = wait_q + 1'b1;
            if (wait_d == WaitW'(TIMEOUT)) begin
              state_d = StIdle;
              err_d   = 1'b1;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    mem_rd_d   = (state_d == StFetch);
    busy_d     = (state_d != StIdle);
    // address tracks the byte being read only while fetching, otherwise parks on base
    mem_addr_d = mem_rd_d ? base_d + ADDR_WIDTH'(idx_d) : base_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      inst     <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      inst     <= inst_d;
      mem_addr <= mem_addr_d;
      mem_rd   <= mem_rd_d;
      ready    <= ready_d;
      busy     <= busy_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by randomized traffic,
// all checked each cycle against a behavioural fetch model and a byte memory image.
module tb_ifetch;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 32;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst_n, en, flush, mem_ready;
  logic [AW-1:0] pc, mem_addr;
  logic          mem_rd, ready, busy, err;
  logic [7:0]    mem_data;
  logic [IW-1:0] inst;

  always #5 clk = ~clk;

  ifetch #(
    .ADDR_WIDTH(AW),
    .INST_WIDTH(IW),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .pc       (pc),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .mem_ready(mem_ready),
    .inst     (inst),
    .ready    (ready),
    .busy     (busy),
    .err      (err)
  );

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model of the fetch unit
  bit          m_fetch, m_done, m_ready, m_err;
  int          m_base, m_idx, m_wait;
  logic [31:0] m_inst;

  function automatic logic [31:0] mem_word(input int b);
    return {mem[(b + 3) % 256], mem[(b + 2) % 256], mem[(b + 1) % 256], mem[b % 256]};
  endfunction

  function automatic int exp_addr();
    return m_fetch ? (m_base + m_idx) % 256 : m_base;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    m_ready = 1'b0;
    m_err   = 1'b0;
    if (!rst_n) begin
      m_fetch = 0; m_done = 0; m_base = 0; m_idx = 0; m_wait = 0; m_inst = '0;
    end else if (flush) begin
      m_fetch = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_fetch) begin
      if (mem_ready) begin
        m_inst[8*m_idx +: 8] = mem_data;
        m_idx++;
        m_wait = 0;
        if (m_idx == 4) begin
          m_fetch = 0; m_done = 1; m_ready = 1; m_idx = 0;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_fetch = 0; m_err = 1;
        end
      end
    end else if (en) begin
      m_fetch = 1; m_base = pc; m_idx = 0; m_wait = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit f, input bit rdy,
                       input logic [7:0] p);
    @(negedge clk);
    rst_n     = r;
    en        = e;
    flush     = f;
    mem_ready = rdy;
    pc        = p;
    mem_data  = mem[exp_addr()];
    @(posedge clk);
    model_step();
    #1;
    check_eq("mem_rd", 32'(mem_rd), 32'(m_fetch));
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr()));
    check_eq("busy", 32'(busy), 32'(m_fetch | m_done));
    check_eq("ready", 32'(ready), 32'(m_ready));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("inst", inst, m_inst);
    if (m_ready) check_eq("word", inst, mem_word(m_base));
  endtask

  initial begin
    bit slow;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h93; mem[8'h11] = 8'h00; mem[8'h12] = 8'h50; mem[8'h13] = 8'h00;
    m_fetch = 0; m_done = 0; m_base = 0; m_idx = 0; m_wait = 0; m_inst = '0;

    // reset state
    cycle(0, 1, 0, 1, 8'h55);
    cycle(0, 0, 0, 0, 8'h00);

    // basic fetch with mem_ready tied high, latency and word value
    cycle(1, 1, 0, 1, 8'h10);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1, 8'h00);
    check_eq("lat_early", 32'(ready), 32'd0);
    cycle(1, 0, 0, 1, 8'h00);
    check_eq("lat34", 32'(ready), 32'd1);
    check_eq("inst34", inst, 32'h00500093);
    cycle(1, 0, 0, 1, 8'h00);

    // address wrap
    cycle(1, 1, 0, 1, 8'hFE);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 1, 8'h00);
    check_eq("wrap", inst, {mem[1], mem[0], mem[255], mem[254]});

    // three stall cycles per byte
    cycle(1, 1, 0, 1, 8'h40);
    for (int k = 0; k < 16; k++) cycle(1, 0, 0, (k % 4) == 3, 8'h00);
    check_eq("stall_rdy", 32'(ready), 32'd1);
    cycle(1, 0, 0, 1, 8'h00);

    // timeout
    cycle(1, 1, 0, 1, 8'h80);
    for (int k = 0; k < 15; k++) cycle(1, 0, 0, 0, 8'h00);
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 8'h00);

    // flush after byte 1, then en together with flush in idle
    cycle(1, 1, 0, 1, 8'h20);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 0, 1, 1, 8'h00);
    check_eq("flush_busy", 32'(busy), 32'd0);
    cycle(1, 1, 1, 1, 8'h30);
    check_eq("flush_en", 32'(busy), 32'd0);

    // en during fetch ignored, then reset after byte 2
    cycle(1, 1, 0, 1, 8'h60);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 1, 0, 1, 8'h99);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
    check_eq("rst_inst", inst, 32'h0);

    // randomized traffic
    slow = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) slow = ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 29) == 0,
            slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7),
            8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
